// File: rtl/calc_sequencer.sv
// Sequences pixel x weight reads through a MAC per output neuron, then scales, saturates and stores each sum.
// 394 cycles per neuron (392 issue, 1 drain, 1 write); no backpressure, RAMs answer with fixed 1-cycle latency.
module calc_sequencer #(
    parameter int NUM_OUT = 10,
    parameter int WORDS   = 392,
    parameter int SHIFT   = 8,
    parameter int ACC_W   = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_calc,
    input  logic        clear_data,
    output logic [8:0]  pixel_addr,
    output logic        pixel_re,
    input  logic [15:0] pixel_rdata,
    output logic [11:0] weight_addr,
    output logic        weight_re,
    input  logic [31:0] weight_rdata,
    output logic        result_we,
    output logic [3:0]  result_addr,
    output logic [16:0] result_data,
    output logic        busy,
    output logic        done_calc,
    output logic        overflow
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    localparam logic [8:0] I_LAST = 9'(WORDS - 1);
    localparam logic [3:0] N_LAST = 4'(NUM_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(65535);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-65536);

    state_t r_state, w_next;
    logic [8:0]  r_i;
    logic [11:0] r_w;
    logic [3:0]  r_n;
    logic signed [ACC_W-1:0] r_acc;
    logic r_ovf;

    logic w_start, w_accum, w_hi, w_lo;
    logic signed [24:0] w_px0, w_px1, w_wt0, w_wt1, w_prod0, w_prod1;
    logic signed [ACC_W-1:0] w_sum, w_scaled;
    logic [16:0] w_sat_data;

    // Pixels are unsigned bytes, weights signed halfwords; each product fits 25 bits.
    assign w_px0   = 25'({1'b0, pixel_rdata[7:0]});
    assign w_px1   = 25'({1'b0, pixel_rdata[15:8]});
    assign w_wt0   = 25'($signed(weight_rdata[15:0]));
    assign w_wt1   = 25'($signed(weight_rdata[31:16]));
    assign w_prod0 = w_px0 * w_wt0;
    assign w_prod1 = w_px1 * w_wt1;
    assign w_sum   = r_acc + ACC_W'(w_prod0) + ACC_W'(w_prod1);

    assign w_scaled   = r_acc >>> SHIFT;
    assign w_hi       = w_scaled > SAT_MAX;
    assign w_lo       = w_scaled < SAT_MIN;
    assign w_sat_data = w_hi ? 17'h0FFFF : (w_lo ? 17'h10000 : w_scaled[16:0]);
    assign overflow   = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_accum     = 1'b0;
        pixel_re    = 1'b0;
        weight_re   = 1'b0;
        pixel_addr  = '0;
        weight_addr = '0;
        result_we   = 1'b0;
        result_addr = '0;
        result_data = '0;
        busy        = 1'b0;
        done_calc   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_calc) begin
                    w_next  = ISSUE;
                    w_start = 1'b1;
                end
            end
            ISSUE: begin
                busy        = 1'b1;
                pixel_re    = 1'b1;
                weight_re   = 1'b1;
                pixel_addr  = r_i;
                weight_addr = r_w;
                w_accum     = (r_i != 9'd0);
                if (r_i == I_LAST) w_next = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                w_accum = 1'b1;
                w_next  = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                result_we   = 1'b1;
                result_addr = r_n;
                result_data = w_sat_data;
                w_next      = (r_n == N_LAST) ? DONE : ISSUE;
            end
            DONE: begin
                done_calc = 1'b1;
                if (start_calc) begin
                    w_next  = ISSUE;
                    w_start = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        // Abort wins over everything, including a write already on the bus this cycle.
        if (clear_data || rst) begin
            w_next    = IDLE;
            w_start   = 1'b0;
            w_accum   = 1'b0;
            result_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i   <= '0;
            r_w   <= '0;
            r_n   <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_i   <= '0;
            r_w   <= '0;
            r_n   <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (clear_data) begin
            r_ovf <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_w <= r_w + 12'd1;
                r_i <= (r_i == I_LAST) ? 9'd0 : r_i + 9'd1;
            end
            if (w_accum) r_acc <= w_sum;
            if (result_we) begin
                r_acc <= '0;
                if (r_n != N_LAST) r_n <= r_n + 4'd1;
                if (w_hi || w_lo)  r_ovf <= 1'b1;
            end
        end
    end
endmodule
